// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Loads hit combinationally in IDLE; misses fill a whole line one word at a
// time from backing memory; stores always go to memory and update the cache
// only when the addressed line is resident.
module dcache_ctrl #(
    parameter int LINES = 16,
    parameter int WPL   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        hit,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);
    localparam int OFF_W = $clog2(WPL);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - OFF_W - IDX_W;
    localparam int LN_W  = 30 - OFF_W;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WPL - 1);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, WDONE} state_t;

    state_t              state_q, state_d;
    logic [OFF_W-1:0]    cnt_q, cnt_d;
    logic [LN_W-1:0]     line_q, line_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [31:0]         mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic [3:0]          mem_be_q, mem_be_d;
    logic [LINES-1:0]    valid_q, valid_d;

    // Tag and data storage carry no reset; valid_q alone decides residency.
    logic [TAG_W-1:0]    tag_q  [LINES];
    logic [31:0]         data_q [LINES*WPL];

    // Single write port shared by line fills and store merges.
    logic                tag_we;
    logic                dwr_en;
    logic [IDX_W+OFF_W-1:0] dwr_addr;
    logic [31:0]         dwr_data;
    logic [3:0]          dwr_be;

    logic                hit_c;
    logic                lookup_hit;
    logic [OFF_W-1:0]    cnt_inc;

    // Address fields of the live request, of the pending store and of the line being filled.
    logic [OFF_W-1:0]    req_off;
    logic [IDX_W-1:0]    req_idx;
    logic [TAG_W-1:0]    req_tag;
    logic [OFF_W-1:0]    wr_off;
    logic [IDX_W-1:0]    wr_idx;
    logic [TAG_W-1:0]    wr_tag;
    logic [IDX_W-1:0]    line_idx;
    logic [TAG_W-1:0]    line_tag;

    assign req_off  = req_addr[OFF_W+1:2];
    assign req_idx  = req_addr[OFF_W+IDX_W+1:OFF_W+2];
    assign req_tag  = req_addr[31:OFF_W+IDX_W+2];
    assign wr_off   = mem_addr_q[OFF_W+1:2];
    assign wr_idx   = mem_addr_q[OFF_W+IDX_W+1:OFF_W+2];
    assign wr_tag   = mem_addr_q[31:OFF_W+IDX_W+2];
    assign line_idx = line_q[IDX_W-1:0];
    assign line_tag = line_q[LN_W-1:IDX_W];

    assign cnt_inc    = cnt_q + 1'b1;
    assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign rdata      = data_q[{req_idx, req_off}];

    // hit is suppressed for as long as reset is held, whatever the FSM says.
    assign hit       = hit_c && !reset;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;

    // Next-state, memory-request and cache-write decisions for the controller FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        line_d      = line_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        valid_d     = valid_q;
        hit_c       = 1'b0;
        tag_we      = 1'b0;
        dwr_en      = 1'b0;
        dwr_addr    = {line_idx, cnt_q};
        dwr_data    = mem_rdata;
        dwr_be      = 4'hF;

        case (state_q)
            IDLE: begin
                if (req_wr) begin
                    state_d     = WRITE;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = req_addr & 32'hFFFF_FFFC;
                    mem_wdata_d = req_wdata;
                    mem_be_d    = req_be;
                end else if (req_rd && !lookup_hit) begin
                    // The victim line is dropped up front so a partial fill is never resident.
                    state_d           = FILL;
                    cnt_d             = '0;
                    line_d            = req_addr[31:OFF_W+2];
                    valid_d[req_idx]  = 1'b0;
                    mem_req_d         = 1'b1;
                    mem_we_d          = 1'b0;
                    mem_addr_d        = {req_addr[31:OFF_W+2], {OFF_W{1'b0}}, 2'b00};
                    mem_be_d          = 4'hF;
                end else begin
                    hit_c = 1'b1;
                end
            end
            FILL: begin
                if (mem_req_q && mem_ready) begin
                    dwr_en     = 1'b1;
                    cnt_d      = cnt_inc;
                    mem_addr_d = {line_q, cnt_inc, 2'b00};
                    if (cnt_q == LAST_WORD) begin
                        state_d           = IDLE;
                        mem_req_d         = 1'b0;
                        valid_d[line_idx] = 1'b1;
                        tag_we            = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (mem_req_q && mem_ready) begin
                    state_d   = WDONE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag)) begin
                        dwr_en   = 1'b1;
                        dwr_addr = {wr_idx, wr_off};
                        dwr_data = mem_wdata_q;
                        dwr_be   = mem_be_q;
                    end
                end
            end
            WDONE: begin
                hit_c   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state and registered memory request, cleared asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            line_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            line_q      <= line_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            valid_q     <= valid_d;
        end
    end

    // Tag and byte-enabled data array writes.
    always_ff @(posedge clock) begin
        if (tag_we) begin
            tag_q[line_idx] <= line_tag;
        end
        if (dwr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (dwr_be[b]) begin
                    data_q[dwr_addr][8*b +: 8] <= dwr_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed scenarios followed by random loads/stores,
// all compared against a behavioural cache + backing-memory model.
module tb_dcache_ctrl;
    localparam int LINES = 16;
    localparam int WPL   = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_rd, req_wr;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        hit;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    dcache_ctrl #(.LINES(LINES), .WPL(WPL)) dut (
        .clock(clock), .reset(reset),
        .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be),
        .hit(hit), .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Memory transactions accepted during the current access.
    logic [31:0] log_addr  [$];
    logic        log_we    [$];
    logic [31:0] log_wdata [$];
    logic [3:0]  log_be    [$];
    logic        mreq_at_hit;
    int          resp_c, hit_c;

    // Behavioural model: backing memory plus cache contents.
    logic [31:0] bmem [logic [29:0]];
    bit          mvalid [LINES];
    int unsigned mtag   [LINES];
    logic [31:0] mdata  [LINES][WPL];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bm_read(input logic [31:0] a);
        if (bmem.exists(a[31:2])) return bmem[a[31:2]];
        return {a[31:2], 2'b00} ^ 32'h5EED_0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic int unsigned line_base(input logic [31:0] a);
        int unsigned u;
        u = a;
        return u - (u % (4 * WPL));
    endfunction

    task automatic model_read(input logic [31:0] a, output bit eh, output logic [31:0] ed);
        int unsigned u, idx, off, tg;
        u = a; idx = (u / (4 * WPL)) % LINES; off = (u / 4) % WPL; tg = u / (4 * WPL * LINES);
        eh = mvalid[idx] && (mtag[idx] == tg);
        if (!eh) begin
            for (int w = 0; w < WPL; w++) mdata[idx][w] = bm_read(line_base(a) + 4 * w);
            mvalid[idx] = 1'b1;
            mtag[idx]   = tg;
        end
        ed = mdata[idx][off];
    endtask

    task automatic model_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        int unsigned u, idx, off, tg;
        u = a; idx = (u / (4 * WPL)) % LINES; off = (u / 4) % WPL; tg = u / (4 * WPL * LINES);
        bmem[a[31:2]] = merge(bm_read(a), wd, be);
        if (mvalid[idx] && (mtag[idx] == tg)) mdata[idx][off] = merge(mdata[idx][off], wd, be);
    endtask

    // Present one request (called at posedge+1) and act as backing memory until hit or abort.
    task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                          input int abort_after, output bit fh, output logic [31:0] got, output bit ab);
        bit done;
        int lat;
        log_addr.delete(); log_we.delete(); log_wdata.delete(); log_be.delete();
        req_addr = a; req_wdata = wd; req_be = be; req_wr = wr; req_rd = !wr;
        fh = 1'b0; got = 'x; ab = 1'b0; done = 1'b0; mreq_at_hit = 1'bx;
        resp_c = -10; hit_c = -1;
        lat = $urandom_range(0, 2);
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clock);
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            if (hit) begin
                if (c == 0) fh = 1'b1;
                got = rdata; mreq_at_hit = mem_req; hit_c = c; done = 1'b1;
            end else if (abort_after >= 0 && log_addr.size() == abort_after) begin
                ab = 1'b1; done = 1'b1;
            end else if (mem_req) begin
                if (lat > 0) lat--;
                else begin
                    mem_ready = 1'b1;
                    if (!mem_we) mem_rdata = bm_read(mem_addr);
                    log_addr.push_back(mem_addr); log_we.push_back(mem_we);
                    log_wdata.push_back(mem_wdata); log_be.push_back(mem_be);
                    resp_c = c;
                    lat = $urandom_range(0, 2);
                end
            end else if ($urandom_range(0, 3) == 0) begin
                mem_ready = 1'b1;
            end
        end
        if (!done) chk("access timeout", 32'(done), 32'd1);
        if (!ab) begin
            @(posedge clock); #1;
            req_rd = 1'b0; req_wr = 1'b0;
        end
    endtask

    task automatic do_read(input logic [31:0] a, input string nm, output bit fh, output logic [31:0] got);
        bit eh, ab;
        logic [31:0] ed;
        access(1'b0, a, 32'h0, 4'h0, -1, fh, got, ab);
        model_read(a, eh, ed);
        chk({nm, " first-cycle hit"}, 32'(fh), 32'(eh));
        if (eh) begin
            chk({nm, " mem txns"}, log_addr.size(), 0);
            chk({nm, " mem_req at hit"}, 32'(mreq_at_hit), 0);
        end else begin
            chk({nm, " fill txns"}, log_addr.size(), WPL);
            for (int i = 0; i < WPL && i < log_addr.size(); i++) begin
                chk({nm, " fill addr"}, log_addr[i], line_base(a) + 4 * i);
                chk({nm, " fill we"}, 32'(log_we[i]), 0);
            end
            chk({nm, " hit after fill"}, hit_c, resp_c + 1);
        end
        chk({nm, " rdata"}, got, ed);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be, input string nm);
        bit fh, ab;
        logic [31:0] got;
        access(1'b1, a, wd, be, -1, fh, got, ab);
        chk({nm, " first-cycle hit"}, 32'(fh), 0);
        chk({nm, " mem txns"}, log_addr.size(), 1);
        if (log_addr.size() > 0) begin
            chk({nm, " wr addr"}, log_addr[0], a & 32'hFFFF_FFFC);
            chk({nm, " wr we"}, 32'(log_we[0]), 1);
            chk({nm, " wr data"}, log_wdata[0], wd);
            chk({nm, " wr be"}, 32'(log_be[0]), 32'(be));
        end
        chk({nm, " wdone latency"}, hit_c, resp_c + 1);
        chk({nm, " mem_req in wdone"}, 32'(mreq_at_hit), 0);
        model_write(a, wd, be);
    endtask

    initial begin
        bit fh, ab;
        logic [31:0] got, a, wd;
        logic [3:0] be;
        req_rd = 0; req_wr = 0; req_addr = 0; req_wdata = 0; req_be = 0;
        mem_ready = 0; mem_rdata = 0;
        for (int l = 0; l < LINES; l++) mvalid[l] = 1'b0;
        for (int w = 0; w < 4; w++) bmem[30'((32'h100 + 4 * w) >> 2)] = 32'hA0 + w;

        // Reset state, checked while reset is still high (no request pending).
        #3;
        chk("reset hit", 32'(hit), 0);
        chk("reset mem_req", 32'(mem_req), 0);
        chk("reset mem_we", 32'(mem_we), 0);
        chk("reset mem_addr", mem_addr, 0);
        chk("reset mem_wdata", mem_wdata, 0);
        chk("reset mem_be", 32'(mem_be), 0);
        #14 reset = 1'b0;
        @(posedge clock); #1;

        // Cold read, then hit in the same line.
        do_read(32'h0000_0104, "cold rd 104", fh, got);
        chk("cold rd 104 missed", 32'(fh), 0);
        chk("cold rd 104 value", got, 32'hA1);
        do_read(32'h0000_010C, "rd 10c", fh, got);
        chk("rd 10c hit", 32'(fh), 1);
        chk("rd 10c value", got, 32'hA3);

        // Store hit merges into the resident word.
        do_write(32'h0000_0104, 32'h0000_BEEF, 4'b0011, "st 104");
        do_read(32'h0000_0104, "rd 104 after st", fh, got);
        chk("rd 104 after st hit", 32'(fh), 1);
        chk("rd 104 after st value", got, 32'h0000_BEEF);

        // Store miss does not allocate.
        do_write(32'h0000_0200, 32'h1234_5678, 4'hF, "st 200");
        do_read(32'h0000_0200, "rd 200", fh, got);
        chk("rd 200 missed", 32'(fh), 0);
        chk("rd 200 value", got, 32'h1234_5678);

        // Conflict eviction.
        do_read(32'h0000_1104, "rd 1104", fh, got);
        chk("rd 1104 missed", 32'(fh), 0);
        do_read(32'h0000_0104, "re-rd 104", fh, got);
        chk("re-rd 104 missed", 32'(fh), 0);

        // Evict again, then reset in the middle of the next fill.
        do_read(32'h0000_1104, "rd 1104 again", fh, got);
        access(1'b0, 32'h0000_0104, 32'h0, 4'h0, 2, fh, got, ab);
        chk("midfill abort reached", 32'(ab), 1);
        chk("midfill words", log_addr.size(), 2);
        #2 reset = 1'b1;
        #1;
        chk("midfill reset mem_req", 32'(mem_req), 0);
        chk("midfill reset hit", 32'(hit), 0);
        req_rd = 1'b0;
        for (int l = 0; l < LINES; l++) mvalid[l] = 1'b0;
        @(negedge clock); #2 reset = 1'b0;
        @(posedge clock); #1;
        do_read(32'h0000_0104, "post-reset rd 104", fh, got);
        chk("post-reset rd 104 missed", 32'(fh), 0);

        // Random loads and stores over a small address pool to force hits and conflicts.
        for (int n = 0; n < 60; n++) begin
            a = (32'($urandom_range(0, 1)) << 12) | (32'($urandom_range(0, 2)) << 8) |
                (32'($urandom_range(0, 3)) << 4) | (32'($urandom_range(0, 3)) << 2) |
                32'($urandom_range(0, 3));
            wd = $urandom;
            be = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) do_write(a, wd, be, "rand st");
            else do_read(a, "rand rd", fh, got);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
